// File: rtl/expression_pipe.sv
// Per-lane ALU over packed operand vectors: add/sub/mul/shifts/compare/xnor/nor-reduce.
// Latency 2 cycles (S1 captures operands, S2 computes and registers y), 1 beat/cycle throughput.
// Backpressure: stall propagates back through the valid-ready chain; y and S1 hold while out_ready is low.
// Optional feature: define EXPRESSION_PIPE_SAT_EN to saturate add/sub per lane instead of wrapping.
module expression_pipe #(
    parameter int WIDTH = 6,
    parameter int LANES = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [2:0]             op,
    input  logic [LANES-1:0]       sgn,
    input  logic [LANES*WIDTH-1:0] a,
    input  logic [LANES*WIDTH-1:0] b,
    output logic [LANES*WIDTH-1:0] y,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [15:0]            done_cnt
);

    // Single-lane evaluation; signedness only matters for shr, compare and saturation.
    function automatic logic [WIDTH-1:0] lane_calc(
        input logic [2:0]       f,
        input logic             s,
        input logic [WIDTH-1:0] x,
        input logic [WIDTH-1:0] z
    );
        logic [WIDTH-1:0]        r;
        logic signed [WIDTH-1:0] xs;
        logic                    lt;
`ifdef EXPRESSION_PIPE_SAT_EN
        logic [WIDTH:0]          ext;
        logic [WIDTH-1:0]        smax;
        logic [WIDTH-1:0]        smin;
`endif
        r  = '0;
        xs = x;
        lt = s ? ($signed(x) < $signed(z)) : (x < z);
`ifdef EXPRESSION_PIPE_SAT_EN
        smax = {1'b0, {(WIDTH-1){1'b1}}};
        smin = {1'b1, {(WIDTH-1){1'b0}}};
        ext  = '0;
`endif
        case (f)
            3'd0: begin
`ifdef EXPRESSION_PIPE_SAT_EN
                ext = {1'b0, x} + {1'b0, z};
                if (s) begin
                    // Signed overflow: like-signed operands producing an opposite-signed sum.
                    if (x[WIDTH-1] == z[WIDTH-1] && ext[WIDTH-1] != x[WIDTH-1])
                        r = x[WIDTH-1] ? smin : smax;
                    else
                        r = ext[WIDTH-1:0];
                end else begin
                    r = ext[WIDTH] ? '1 : ext[WIDTH-1:0];
                end
`else
                r = x + z;
`endif
            end
            3'd1: begin
`ifdef EXPRESSION_PIPE_SAT_EN
                ext = {1'b0, x} - {1'b0, z};
                if (s) begin
                    // Signed overflow: unlike-signed operands where the result loses A's sign.
                    if (x[WIDTH-1] != z[WIDTH-1] && ext[WIDTH-1] != x[WIDTH-1])
                        r = x[WIDTH-1] ? smin : smax;
                    else
                        r = ext[WIDTH-1:0];
                end else begin
                    r = ext[WIDTH] ? '0 : ext[WIDTH-1:0];
                end
`else
                r = x - z;
`endif
            end
            // Low WIDTH bits of a product are identical for signed and unsigned operands.
            3'd2: r = x * z;
            3'd3: begin
                if (32'(z) >= WIDTH)
                    r = s ? {WIDTH{x[WIDTH-1]}} : '0;
                else if (s)
                    r = xs >>> z;
                else
                    r = x >> z;
            end
            3'd4: r = (32'(z) >= WIDTH) ? '0 : (x << z);
            3'd5: r = {{(WIDTH-1){1'b0}}, lt};
            3'd6: r = ~(x ^ z);
            default: r = {{(WIDTH-1){1'b0}}, ~|x};
        endcase
        return r;
    endfunction

    logic                   v1_q;
    logic [2:0]             op1_q;
    logic [LANES-1:0]       sgn1_q;
    logic [LANES*WIDTH-1:0] a1_q;
    logic [LANES*WIDTH-1:0] b1_q;
    logic                   v2_q;
    logic [LANES*WIDTH-1:0] y_q;
    logic [LANES*WIDTH-1:0] y_d;
    logic [15:0]            done_q;
    logic [15:0]            done_d;
    logic                   rdy1;
    logic                   rdy2;

    assign rdy2      = ~v2_q | out_ready;
    assign rdy1      = ~v1_q | rdy2;
    assign in_ready  = rdy1;
    assign out_valid = v2_q;
    assign y         = y_q;
    assign done_cnt  = done_q;

    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            assign y_d[gi*WIDTH +: WIDTH] = lane_calc(op1_q, sgn1_q[gi],
                                                      a1_q[gi*WIDTH +: WIDTH],
                                                      b1_q[gi*WIDTH +: WIDTH]);
        end
    endgenerate

    // Completed-transfer count, free-running 16-bit wrap.
    always_comb begin
        done_d = done_q;
        if (v2_q & out_ready) done_d = done_q + 16'd1;
    end

    // Stage 1: capture the accepted beat; holds while stage 2 is stalled.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            v1_q   <= 1'b0;
            op1_q  <= '0;
            sgn1_q <= '0;
            a1_q   <= '0;
            b1_q   <= '0;
        end else if (rdy1) begin
            v1_q <= in_valid;
            if (in_valid) begin
                op1_q  <= op;
                sgn1_q <= sgn;
                a1_q   <= a;
                b1_q   <= b;
            end
        end
    end

    // Stage 2: register lane results; y only changes when a new valid beat moves in.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            v2_q <= 1'b0;
            y_q  <= '0;
        end else if (rdy2) begin
            v2_q <= v1_q;
            if (v1_q) y_q <= y_d;
        end
    end

    // Output transfer counter register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) done_q <= '0;
        else       done_q <= done_d;
    end

endmodule

// File: tb/tb_expression_pipe.sv
// Directed bench for expression_pipe at WIDTH=6, LANES=4.
// Every beat is checked for 2-cycle latency and per-lane results against hand-computed values.
// Covers stall/drain ordering, done_cnt, and asynchronous reset with both stages full.
module tb_expression_pipe;
    localparam int W = 6;
    localparam int L = 4;

    logic           clk = 1'b0;
    logic           reset;
    logic           in_valid;
    logic           in_ready;
    logic [2:0]     op;
    logic [L-1:0]   sgn;
    logic [L*W-1:0] a;
    logic [L*W-1:0] b;
    logic [L*W-1:0] y;
    logic           out_valid;
    logic           out_ready;
    logic [15:0]    done_cnt;

    int n_cmp = 0;
    int n_err = 0;

    expression_pipe #(.WIDTH(W), .LANES(L)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .sgn(sgn), .a(a), .b(b), .y(y), .out_valid(out_valid),
        .out_ready(out_ready), .done_cnt(done_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [L*W-1:0] pk(input logic [W-1:0] l0, input logic [W-1:0] l1,
                                          input logic [W-1:0] l2, input logic [W-1:0] l3);
        return {l3, l2, l1, l0};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive one beat with out_ready high and check it appears exactly two edges later.
    task automatic run_beat(input string tag, input logic [2:0] f, input logic [L-1:0] s,
                            input logic [L*W-1:0] av, input logic [L*W-1:0] bv,
                            input logic [L*W-1:0] yexp);
        op = f; sgn = s; a = av; b = bv; in_valid = 1'b1;
        check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        check({tag, "_valid_c1"}, 32'(out_valid), 32'd0);
        @(posedge clk); #1;
        check({tag, "_valid_c2"}, 32'(out_valid), 32'd1);
        check({tag, "_y"}, 32'(y), 32'(yexp));
    endtask

    logic [L*W-1:0] add_exp;
    logic [L*W-1:0] sub_exp;

    initial begin
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        op = '0; sgn = '0; a = '0; b = '0;
`ifdef EXPRESSION_PIPE_SAT_EN
        add_exp = pk(6'b000010, 6'b011111, 6'd63, 6'd30);
        sub_exp = pk(6'd0, 6'b100000, 6'd13, 6'b111100);
`else
        add_exp = pk(6'b000010, 6'b100000, 6'd0, 6'd30);
        sub_exp = pk(6'b111110, 6'b011111, 6'd13, 6'b111100);
`endif
        #2;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_done_cnt", 32'(done_cnt), 32'd0);
        check("rst_y", 32'(y), 32'd0);
        @(posedge clk); #1;
        @(posedge clk); #3;
        reset = 1'b0;
        @(posedge clk); #1;
        check("post_rst_in_ready", 32'(in_ready), 32'd1);

        // add: lane0 -3+5 signed, lane1 31+1 signed overflow, lane2 63+1 unsigned carry, lane3 10+20
        run_beat("add", 3'd0, 4'b0011, pk(6'b111101, 6'd31, 6'd63, 6'd10),
                 pk(6'd5, 6'd1, 6'd1, 6'd20), add_exp);
        // shr: signed/unsigned by 2, signed by 7 (all sign bits), unsigned by 6 (zero)
        run_beat("shr", 3'd3, 4'b0101, pk(6'b111000, 6'b111000, 6'b111000, 6'b111000),
                 pk(6'd2, 6'd2, 6'd7, 6'd6), pk(6'b111110, 6'b001110, 6'b111111, 6'd0));
        // lt: -1<1 signed, 63<1 unsigned, 2<-2 signed, 2<62 unsigned
        run_beat("lt", 3'd5, 4'b0101, pk(6'd63, 6'd63, 6'd2, 6'd2),
                 pk(6'd1, 6'd1, 6'd62, 6'd62), pk(6'd1, 6'd0, 6'd0, 6'd1));
        // sub: 3-5 unsigned borrow, -32-1 signed overflow, 20-7, 5-9 signed
        run_beat("sub", 3'd1, 4'b1010, pk(6'd3, 6'b100000, 6'd20, 6'd5),
                 pk(6'd5, 6'd1, 6'd7, 6'd9), sub_exp);
        run_beat("mul", 3'd2, 4'b1001, pk(6'd61, 6'd7, 6'd12, 6'd63),
                 pk(6'd5, 6'd9, 6'd12, 6'd63), pk(6'd49, 6'd63, 6'd16, 6'd1));
        run_beat("shl", 3'd4, 4'b0000, pk(6'd7, 6'd63, 6'd1, 6'd3),
                 pk(6'd2, 6'd6, 6'd5, 6'd63), pk(6'd28, 6'd0, 6'd32, 6'd0));
        run_beat("xnor", 3'd6, 4'b1111, pk(6'd42, 6'd0, 6'd63, 6'd15),
                 pk(6'd51, 6'd0, 6'd0, 6'd15), pk(6'd38, 6'd63, 6'd0, 6'd63));
        run_beat("nor", 3'd7, 4'b0000, pk(6'd0, 6'd1, 6'd32, 6'd0),
                 pk(6'd5, 6'd0, 6'd0, 6'd63), pk(6'd1, 6'd0, 6'd0, 6'd1));
        @(posedge clk); #1;
        check("drain8_valid", 32'(out_valid), 32'd0);
        check("drain8_done", 32'(done_cnt), 32'd8);

        // Fill both stages under stall, then reset between clock edges.
        out_ready = 1'b0;
        op = 3'd0; sgn = '0; a = pk(6'd1, 6'd1, 6'd1, 6'd1); b = '0; in_valid = 1'b1;
        @(posedge clk); #1;
        a = pk(6'd2, 6'd2, 6'd2, 6'd2);
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("full_out_valid", 32'(out_valid), 32'd1);
        check("full_in_ready", 32'(in_ready), 32'd0);
        #2 reset = 1'b1;
        #1;
        check("arst_out_valid", 32'(out_valid), 32'd0);
        check("arst_done", 32'(done_cnt), 32'd0);
        check("arst_y", 32'(y), 32'd0);
        #2 reset = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("rel_in_ready", 32'(in_ready), 32'd1);
        check("rel_no_stale", 32'(out_valid), 32'd0);
        run_beat("rel_beat", 3'd0, 4'b0000, pk(6'd4, 6'd5, 6'd6, 6'd7),
                 pk(6'd1, 6'd1, 6'd1, 6'd1), pk(6'd5, 6'd6, 6'd7, 6'd8));
        @(posedge clk); #1;
        check("rel_done", 32'(done_cnt), 32'd1);

        // Stream three beats into a stalled consumer, then drain in order.
        out_ready = 1'b0;
        op = 3'd0; sgn = '0; b = pk(6'd1, 6'd1, 6'd1, 6'd1);
        a = pk(6'd1, 6'd2, 6'd3, 6'd4); in_valid = 1'b1;
        check("st_rdy0", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        check("st_rdy1", 32'(in_ready), 32'd1);
        a = pk(6'd10, 6'd11, 6'd12, 6'd13);
        @(posedge clk); #1;
        check("st_rdy2", 32'(in_ready), 32'd0);
        check("st_valid2", 32'(out_valid), 32'd1);
        check("st_y1", 32'(y), 32'(pk(6'd2, 6'd3, 6'd4, 6'd5)));
        a = pk(6'd20, 6'd21, 6'd22, 6'd23);
        @(posedge clk); #1;
        check("st_hold_y1", 32'(y), 32'(pk(6'd2, 6'd3, 6'd4, 6'd5)));
        check("st_hold_rdy", 32'(in_ready), 32'd0);
        out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("st_y2", 32'(y), 32'(pk(6'd11, 6'd12, 6'd13, 6'd14)));
        @(posedge clk); #1;
        check("st_y3", 32'(y), 32'(pk(6'd21, 6'd22, 6'd23, 6'd24)));
        check("st_valid3", 32'(out_valid), 32'd1);
        @(posedge clk); #1;
        check("st_empty", 32'(out_valid), 32'd0);
        check("st_done", 32'(done_cnt), 32'd4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/expression_pipe.md
EXPRESSION_PIPE -- requirements
Module: expression_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 6, the lane operand and result width in bits (legal range 2..32).
REQ-002 SHALL have parameter LANES, default 4, the number of independent lanes (legal range 1..16).
REQ-003 SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port in_valid, input, 1 bit: the input beat is valid.
REQ-006 SHALL have port in_ready, output, 1 bit: the block accepts the input beat.
REQ-007 SHALL have port op, input, 3 bits: operation select, common to all lanes.
REQ-008 SHALL have port sgn, input, LANES bits: per-lane signed mode, 1 = two's complement.
REQ-009 SHALL have port a, input, LANES*WIDTH bits: lane i operand A is a[i*WIDTH +: WIDTH].
REQ-010 SHALL have port b, input, LANES*WIDTH bits: lane i operand B, packed the same way as a.
REQ-011 SHALL have port y, output, LANES*WIDTH bits: lane results, packed the same way as a.
REQ-012 SHALL have port out_valid, output, 1 bit: y is valid.
REQ-013 SHALL have port out_ready, input, 1 bit: the consumer accepts y.
REQ-014 SHALL have port done_cnt, output, 16 bits: count of completed output transfers.

Function
REQ-015 SHALL be a 2-stage pipeline: S1 registers op, sgn, a and b; S2 computes and registers y.
REQ-016 SHALL use the ready rules: rdy2 = ~v2 | out_ready; rdy1 = ~v1 | rdy2; in_ready = rdy1.
REQ-017 SHALL accept a beat on in_valid & in_ready; S1 and S2 load only when their own rdy is high.
REQ-018 SHALL present y two cycles after acceptance when there is no stall, with a throughput of 1 beat per cycle.
REQ-019 SHALL hold y, out_valid and S1 contents stable while out_valid & ~out_ready; no beat is dropped or duplicated.
REQ-020 SHALL compute op=0 as A+B, truncated to WIDTH.
REQ-021 SHALL compute op=1 as A-B, truncated to WIDTH.
REQ-022 SHALL compute op=2 as A*B, keeping the low WIDTH bits of the product (sign-correct when sgn=1).
REQ-023 SHALL compute op=3 as A>>B, with B taken as unsigned; the shift is arithmetic when sgn=1 and logical otherwise; a shift of B>=WIDTH gives all sign bits (sgn=1) or 0.
REQ-024 SHALL compute op=4 as A<<B, with B taken as unsigned; a shift of B>=WIDTH gives 0.
REQ-025 SHALL compute op=5 as (A<B), compared signed when sgn=1 and unsigned otherwise, zero-extended to WIDTH.
REQ-026 SHALL compute op=6 as bitwise A~^B.
REQ-027 SHALL compute op=7 as ~|A, zero-extended to WIDTH.
REQ-028 SHALL evaluate each lane independently; lane signedness comes only from its sgn bit.
REQ-029 SHALL increment done_cnt on each out_valid & out_ready and wrap from 0xFFFF to 0.
REQ-030 SHALL, on simultaneous accept and output transfer, perform both in the same cycle.

Reset
REQ-031 SHALL, while reset is asserted, force v1=0, v2=0, out_valid=0, y=0 and done_cnt=0 immediately, independent of clk.
REQ-032 SHALL discard all in-flight beats on reset mid-operation; in_ready SHALL be 1 in the first cycle after reset deasserts.

Configuration
REQ-033 SHALL, when macro EXPRESSION_PIPE_SAT_EN is defined, saturate op=0 and op=1 per lane: to [-2^(WIDTH-1), 2^(WIDTH-1)-1] when sgn=1 and to [0, 2^WIDTH-1] when sgn=0.
REQ-034 SHALL, when EXPRESSION_PIPE_SAT_EN is undefined, wrap op=0 and op=1 modulo 2^WIDTH; all other ops are unaffected by the macro.

Verification (WIDTH=6, LANES=4)
REQ-035 SHALL cover: lane0 sgn=1, A=6'b111101 (-3), B=5, op=0 -> y lane0=6'b000010 exactly 2 cycles after accept.
REQ-036 SHALL cover: A=6'b111000, B=2, op=3; with sgn=1 -> 6'b111110, with sgn=0 -> 6'b001110; with B=7 and sgn=1 -> 6'b111111.
REQ-037 SHALL cover: A=6'b111111, B=1, op=5; with sgn=1 -> 1, with sgn=0 -> 0, both in one beat on different lanes.
REQ-038 SHALL cover: sgn=1, A=31, B=1, op=0 -> 6'b100000 without EXPRESSION_PIPE_SAT_EN, and 6'b011111 with it.
REQ-039 SHALL cover: stream 3 beats with out_ready=0 -> in_ready falls after 2 accepts and y holds the first result; raising out_ready drains all 3 in order, and done_cnt=3.
REQ-040 SHALL cover: assert reset with v1=v2=1 -> out_valid=0 and done_cnt=0 without a clock edge; the next beat after release has latency 2.
